// File: rtl/side_pkg.sv
// Shared SIDE core definitions: opcodes, multiply/divide FSM state and the
// long-operation classifier used by the execution units.
package side_pkg;

  localparam logic [5:0] OP_SLL  = 6'h00;
  localparam logic [5:0] OP_SRL  = 6'h02;
  localparam logic [5:0] OP_SRA  = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_SLTU = 6'h2B;

  // Long ops: bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_e;

  function automatic logic is_long_op(input logic [15:0] op);
    return (op == 16'(OP_MULT)) || (op == 16'(OP_MULTU)) ||
           (op == 16'(OP_DIV))  || (op == 16'(OP_DIVU));
  endfunction

endpackage

// File: rtl/ALU.sv
// Combinational single-cycle ALU shared by the execution units.
module ALU
  import side_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = imm[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_W'(OP_ADD), OP_W'(OP_ADDU): result = src1 + src2;
      OP_W'(OP_SUB), OP_W'(OP_SUBU): result = src1 - src2;
      OP_W'(OP_AND):  result = src1 & src2;
      OP_W'(OP_OR):   result = src1 | src2;
      OP_W'(OP_XOR):  result = src1 ^ src2;
      OP_W'(OP_NOR):  result = ~(src1 | src2);
      OP_W'(OP_SLT):  result = DATA_W'($signed(src1) < $signed(src2));
      OP_W'(OP_SLTU): result = DATA_W'(src1 < src2);
      OP_W'(OP_SLL):  result = src2 << shamt;
      OP_W'(OP_SRL):  result = src2 >> shamt;
      OP_W'(OP_SRA):  result = $unsigned($signed(src2) >>> shamt);
      OP_W'(OP_ADDI): result = src1 + imm;
      OP_W'(OP_ANDI): result = src1 & imm;
      OP_W'(OP_ORI):  result = src1 | imm;
      OP_W'(OP_LUI):  result = imm << (DATA_W / 2);
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/md_iter.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes,
// signs and the divide-by-zero quotient restored after the last step.
module md_iter
  import side_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              start,
  input  logic              is_div,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] res_lo,
  output logic [DATA_W-1:0] res_hi
);
  localparam int CNT_W = $clog2(DATA_W);

  logic                busy, div_q, neg_lo, neg_hi, dz, ge;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi, lo, dvs, mag_a, mag_b;
  logic [DATA_W:0]     msum, rsh;
  logic [2*DATA_W-1:0] prod_neg;

  assign mag_a = (is_signed && a[DATA_W-1]) ? -a : a;
  assign mag_b = (is_signed && b[DATA_W-1]) ? -b : b;

  // hi:lo is the product accumulator for multiply, remainder:quotient for divide.
  assign msum = {1'b0, hi} + {1'b0, (lo[0] ? dvs : '0)};
  assign rsh  = {hi, lo[DATA_W-1]};
  assign ge   = rsh >= {1'b0, dvs};
  assign done = busy && (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      dvs    <= '0;
      div_q  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz     <= 1'b0;
    end else if (kill) begin
      busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      hi     <= '0;
      lo     <= mag_a;
      dvs    <= mag_b;
      div_q  <= is_div;
      neg_lo <= is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_hi <= is_signed && a[DATA_W-1];
      dz     <= is_div && (b == '0);
    end else if (busy) begin
      cnt  <= cnt + 1'b1;
      busy <= !done;
      if (div_q) begin
        hi <= ge ? (rsh[DATA_W-1:0] - dvs) : rsh[DATA_W-1:0];
        lo <= {lo[DATA_W-2:0], ge};
      end else begin
        hi <= msum[DATA_W:1];
        lo <= {msum[0], lo[DATA_W-1:1]};
      end
    end
  end

  assign prod_neg = -{hi, lo};

  always_comb begin
    res_lo = lo;
    res_hi = hi;
    if (!div_q) begin
      if (neg_lo) {res_hi, res_lo} = prod_neg;
    end else begin
      if (neg_lo) res_lo = -lo;
      if (neg_hi) res_hi = -hi;
      if (dz)     res_lo = '1;
    end
  end

endmodule

// File: rtl/ex_alu_md_unit.sv
// Execution unit: S1 operand register, combinational ALU or iterative
// multiply/divide, S2 output register with valid/ready on both sides.
module ex_alu_md_unit
  import side_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int CW_W   = 4,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              EX_valid,
  output logic              EX_ready,
  input  logic [OP_W-1:0]   EX_Operation,
  input  logic [DATA_W-1:0] EX_imm,
  input  logic [DATA_W-1:0] EX_Src1,
  input  logic [DATA_W-1:0] EX_Src2,
  input  logic [PREG_W-1:0] EX_Phydst,
  input  logic [CW_W-1:0]   EX_Commit_Window,
  output logic              WB_valid,
  input  logic              WB_ready,
  output logic [DATA_W-1:0] WB_Result,
  output logic [DATA_W-1:0] WB_ResultHi,
  output logic              WB_hilo,
  output logic [PREG_W-1:0] WB_Phydst,
  output logic [CW_W-1:0]   WB_Commit_Window
);
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [PREG_W-1:0] pd;
    logic [CW_W-1:0]   cw;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
    logic              hilo;
    logic [PREG_W-1:0] pd;
    logic [CW_W-1:0]   cw;
  } s2_t;

  logic [2:1]        vld_pipe;
  s1_t               s1;
  s2_t               s2, s2_in;
  md_state_e         state, state_nxt;
  logic              accept, long_in, s2_free, s1_adv, md_done;
  logic [DATA_W-1:0] alu_res, md_lo, md_hi;

  // S1 only advances from IDLE (ALU op) or DONE (finished long op).
  assign s2_free  = !vld_pipe[2] || WB_ready;
  assign s1_adv   = vld_pipe[1] && s2_free && (state == IDLE || state == DONE);
  assign EX_ready = rst && !flush && (state == IDLE) && (!vld_pipe[1] || s1_adv);
  assign accept   = EX_valid && EX_ready;
  assign long_in  = accept && is_long_op(16'(EX_Operation));

  ALU #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .op     (s1.op),
    .src1   (s1.src1),
    .src2   (s1.src2),
    .imm    (s1.imm),
    .result (alu_res)
  );

  md_iter #(.DATA_W(DATA_W)) u_md (
    .clk       (clk),
    .rst       (rst),
    .kill      (flush),
    .start     (long_in),
    .is_div    (EX_Operation[1]),
    .is_signed (!EX_Operation[0]),
    .a         (EX_Src1),
    .b         (EX_Src2),
    .done      (md_done),
    .res_lo    (md_lo),
    .res_hi    (md_hi)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (long_in) state_nxt = RUN;
      RUN:     if (md_done) state_nxt = DONE;
      DONE:    if (s2_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    s2_in.lo   = alu_res;
    s2_in.hi   = '0;
    s2_in.hilo = 1'b0;
    s2_in.pd   = s1.pd;
    s2_in.cw   = s1.cw;
    if (state == DONE) begin
      s2_in.lo   = md_lo;
      s2_in.hi   = md_hi;
      s2_in.hilo = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        vld_pipe <= '0;
      end else begin
        if (accept)      vld_pipe[1] <= 1'b1;
        else if (s1_adv) vld_pipe[1] <= 1'b0;
        if (s1_adv)        vld_pipe[2] <= 1'b1;
        else if (WB_ready) vld_pipe[2] <= 1'b0;
      end
      if (accept)
        s1 <= '{op: EX_Operation, imm: EX_imm, src1: EX_Src1, src2: EX_Src2,
                pd: EX_Phydst, cw: EX_Commit_Window};
      if (s1_adv && !flush) s2 <= s2_in;
    end
  end

  assign WB_valid         = vld_pipe[2];
  assign WB_Result        = s2.lo;
  assign WB_ResultHi      = s2.hi;
  assign WB_hilo          = s2.hilo;
  assign WB_Phydst        = s2.pd;
  assign WB_Commit_Window = s2.cw;

endmodule

// File: tb/tb_ex_alu_md_unit.sv
// Scoreboard bench for ex_alu_md_unit: expected results queued at issue,
// compared in order at each writeback transfer.
module tb_ex_alu_md_unit;
  import side_pkg::*;

  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, EX_valid = 1'b0, WB_ready = 1'b1;
  logic        EX_ready, WB_valid, WB_hilo;
  logic [5:0]  EX_Operation = '0, EX_Phydst = '0, WB_Phydst;
  logic [3:0]  EX_Commit_Window = '0, WB_Commit_Window;
  logic [31:0] EX_imm = '0, EX_Src1 = '0, EX_Src2 = '0, WB_Result, WB_ResultHi;

  ex_alu_md_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .EX_valid(EX_valid), .EX_ready(EX_ready), .EX_Operation(EX_Operation),
    .EX_imm(EX_imm), .EX_Src1(EX_Src1), .EX_Src2(EX_Src2),
    .EX_Phydst(EX_Phydst), .EX_Commit_Window(EX_Commit_Window),
    .WB_valid(WB_valid), .WB_ready(WB_ready), .WB_Result(WB_Result),
    .WB_ResultHi(WB_ResultHi), .WB_hilo(WB_hilo),
    .WB_Phydst(WB_Phydst), .WB_Commit_Window(WB_Commit_Window)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        hilo;
    logic [5:0]  pd;
    logic [3:0]  cw;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, wb_cnt = 0, tag_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after a rising edge; offers one op until accepted.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] lo, input logic [31:0] hi,
                       input logic hilo, input int lat);
    exp_t e;
    int n = 0;
    tag_n++;
    EX_valid = 1'b1; EX_Operation = op; EX_Src1 = a; EX_Src2 = b; EX_imm = imm;
    EX_Phydst = 6'(tag_n % 63 + 1); EX_Commit_Window = 4'(tag_n);
    @(negedge clk);
    while (!EX_ready && n < 100) begin n++; @(negedge clk); end
    if (!EX_ready) chk("issue_timeout", 64'd0, 64'd1);
    else begin
      e.lo = lo; e.hi = hi; e.hilo = hilo; e.pd = EX_Phydst; e.cw = EX_Commit_Window;
      e.cyc = (lat < 0) ? -1 : cyc + lat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    EX_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Writeback monitor: in-order compare, latency, stability while stalled.
  initial begin
    exp_t e;
    logic stalled = 1'b0;
    logic [31:0] snap_lo = '0;
    logic [9:0]  snap_tag = '0;
    forever begin
      @(negedge clk);
      if (!rst) stalled = 1'b0;
      else if (WB_valid) begin
        if (stalled) begin
          chk("stall_lo", 64'(WB_Result), 64'(snap_lo));
          chk("stall_tag", 64'({WB_Phydst, WB_Commit_Window}), 64'(snap_tag));
        end
        if (WB_ready) begin
          if (q.size() == 0) chk("unexpected_wb", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("wb_lo", 64'(WB_Result), 64'(e.lo));
            chk("wb_hi", 64'(WB_ResultHi), 64'(e.hi));
            chk("wb_hilo", 64'(WB_hilo), 64'(e.hilo));
            chk("wb_tag", 64'({WB_Phydst, WB_Commit_Window}), 64'({e.pd, e.cw}));
            if (e.cyc >= 0) chk("latency", 64'(cyc), 64'(e.cyc));
          end
          wb_cnt++;
        end
        stalled  = !WB_ready;
        snap_lo  = WB_Result;
        snap_tag = {WB_Phydst, WB_Commit_Window};
      end else stalled = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", 64'(EX_ready), 64'd0);
    chk("rst_wb_valid", 64'(WB_valid), 64'd0);
    chk("rst_wb_result", 64'(WB_Result), 64'd0);
    chk("rst_wb_hilo", 64'(WB_hilo), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back ALU ops
    issue(OP_ADD, 32'd3, 32'd4, 32'd0, 32'd7, 32'd0, 1'b0, 2);
    issue(OP_ADD, 32'd10, 32'hFFFFFFFF, 32'd0, 32'd9, 32'd0, 1'b0, 2);
    issue(OP_SUB, 32'd5, 32'd7, 32'd0, 32'hFFFFFFFE, 32'd0, 1'b0, 2);
    issue(OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 32'd0, 1'b0, 2);
    issue(OP_SRA, 32'd0, 32'hFFFFFF00, 32'd4, 32'hFFFFFFF0, 32'd0, 1'b0, 2);
    issue(OP_LUI, 32'd0, 32'd0, 32'h1234, 32'h12340000, 32'd0, 1'b0, 2);
    drain();

    // MULT -3 x 5 and the busy window
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'd0, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b1, 34);
    n = 0;
    @(negedge clk);
    while (!EX_ready && n < 100) begin n++; @(negedge clk); end
    chk("mult_busy_cycles", 64'(n), 64'd33);
    @(posedge clk); #1;
    drain();

    // Divide corners and more multiplies, plus an ALU op straight after a long op
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFD, 32'd1, 1'b1, 34);
    issue(OP_DIVU, 32'd5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 34);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd0, 1'b1, 34);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 34);
    issue(OP_DIV, 32'hFFFFFFFB, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 34);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 32'hFFFFFFFE, 1'b1, 34);
    issue(OP_MULT, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h40000000, 1'b1, 34);
    issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd3, 32'd0, 1'b0, 2);
    drain();

    // Long op held 2 cycles in S2 by backpressure
    issue(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 32'd0, 1'b1, 36);
    repeat (33) @(posedge clk); #1;
    WB_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    WB_ready = 1'b1;
    drain();

    // ALU stream with WB_ready low for 3 cycles
    n0 = wb_cnt;
    fork
      for (int i = 0; i < 6; i++)
        issue(OP_ADD, 32'(i), 32'd100, 32'd0, 32'(i + 100), 32'd0, 1'b0, -1);
      begin
        repeat (2) @(posedge clk); #1;
        WB_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        WB_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(wb_cnt), 64'(n0 + 6));

    // Flush in cycle 10 of a DIVU; op offered during the flush is dropped
    issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd14, 32'd2, 1'b1, -1);
    repeat (9) @(posedge clk); #1;
    void'(q.pop_back());
    n0 = wb_cnt;
    flush = 1'b1; EX_valid = 1'b1; EX_Operation = OP_ADD; EX_Src1 = 32'd1; EX_Src2 = 32'd1;
    @(negedge clk);
    chk("ready_in_flush", 64'(EX_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; EX_valid = 1'b0;
    #1;
    chk("ready_after_flush", 64'(EX_ready), 64'd1);
    issue(OP_ADD, 32'd8, 32'd9, 32'd0, 32'd17, 32'd0, 1'b0, 2);
    drain();
    repeat (40) @(posedge clk); #1;
    chk("flush_no_wb", 64'(wb_cnt), 64'(n0 + 1));

    // Flush while S2 drains: the S2 transfer completes, S1 is dropped
    n0 = wb_cnt;
    issue(OP_ADD, 32'd20, 32'd22, 32'd0, 32'd42, 32'd0, 1'b0, 2);
    issue(OP_SUB, 32'd50, 32'd8, 32'd0, 32'd42, 32'd0, 1'b0, -1);
    flush = 1'b1;
    void'(q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("flush_s2_count", 64'(wb_cnt), 64'(n0 + 1));
    chk("flush_s2_queue", 64'(q.size()), 64'd0);

    // Asynchronous reset mid-RUN, then a fresh MULTU
    issue(OP_MULTU, 32'h1234, 32'd3, 32'd0, 32'h369C, 32'd0, 1'b1, -1);
    repeat (5) @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_wb_valid", 64'(WB_valid), 64'd0);
    chk("arst_wb_result", 64'(WB_Result), 64'd0);
    chk("arst_wb_hi", 64'(WB_ResultHi), 64'd0);
    chk("arst_wb_tag", 64'({WB_Phydst, WB_Commit_Window}), 64'd0);
    chk("arst_ex_ready", 64'(EX_ready), 64'd0);
    q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 32'd1, 1'b1, 34);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
